// File: rtl/window_bank_sched.sv
// Ping-pong bank scheduler for the 3x3 window pipeline: the writer fills one BRAM bank
// while the window block reads the other; frame hand-off, stall, completion and timeout live here.
module window_bank_sched #(
  parameter int WIDTH   = 480,
  parameter int HEIGHT  = 272,
  parameter int TIMEOUT = 1024,
  parameter int FCNT_W  = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iRunEn,
  input  logic              iWrFrameDone,
  output logic              oWrReady,
  output logic              oWrBank,
  output logic              oRdBank,
  output logic              oWinEn,
  input  logic              iWinValid,
  input  logic              iOutReady,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic [FCNT_W-1:0] oFrameCnt,
  output logic              oErr
);

  localparam int PIX   = WIDTH * HEIGHT;
  localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} stateT;

  stateT            state;
  logic [1:0]       rFull;
  logic [1:0]       fullNext;
  logic [PIX_W-1:0] pixCnt;
  logic [TO_W-1:0]  toCnt;
  logic             wrAccept;
  logic             winAccept;
  logic             winMiss;
  logic             lastPix;
  logic             toLast;

  assign oWrReady  = !rFull[oWrBank];
  assign wrAccept  = iWrFrameDone && oWrReady;
  assign oWinEn    = (state == RUN) && iOutReady;
  assign winAccept = oWinEn && iWinValid;
  assign winMiss   = oWinEn && !iWinValid;
  assign lastPix   = (pixCnt == PIX_W'(PIX - 1));
  assign toLast    = (toCnt == TO_W'(TIMEOUT - 1));
  assign oBusy     = (state != IDLE);

  // A write accept and a DONE release never hit the same bank: the writer only
  // targets an empty bank, the reader only releases a full one.
  always_comb begin
    fullNext = rFull;
    if (wrAccept)
      fullNext[oWrBank] = 1'b1;
    if (state == DONE)
      fullNext[oRdBank] = 1'b0;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= IDLE;
      rFull      <= 2'b00;
      oWrBank    <= 1'b0;
      oRdBank    <= 1'b0;
      pixCnt     <= '0;
      toCnt      <= '0;
      oFrameDone <= 1'b0;
      oFrameCnt  <= '0;
      oErr       <= 1'b0;
    end else begin
      rFull      <= fullNext;
      oFrameDone <= 1'b0;
      if (wrAccept)
        oWrBank <= ~oWrBank;
      case (state)
        IDLE: begin
          if (iRunEn && rFull[oRdBank])
            state <= RUN;
        end
        RUN: begin
          if (winAccept) begin
            toCnt <= '0;
            if (lastPix) begin
              pixCnt     <= '0;
              state      <= DONE;
              oFrameDone <= 1'b1;
            end else begin
              pixCnt <= pixCnt + PIX_W'(1);
            end
          end else if (winMiss) begin
            // Give up on this attempt but keep the bank full so the next start retries it.
            if (toLast) begin
              oErr   <= 1'b1;
              state  <= IDLE;
              pixCnt <= '0;
              toCnt  <= '0;
            end else begin
              toCnt <= toCnt + TO_W'(1);
            end
          end
        end
        DONE: begin
          oRdBank   <= ~oRdBank;
          oFrameCnt <= oFrameCnt + FCNT_W'(1);
          pixCnt    <= '0;
          toCnt     <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
